// File: rtl/alu_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : alu_ctrl_pkg
// Brief    : ALU control-code constants shared by the ALU and its initiators,
//            plus the state encoding of the multiply sequencer.
// Revision : 1.0 - initial release
// ============================================================================
package alu_ctrl_pkg;

   // ALU operation codes (4-bit control field)
   localparam logic [3:0] c_alu_and  = 4'b0000;
   localparam logic [3:0] c_alu_or   = 4'b0001;
   localparam logic [3:0] c_alu_add  = 4'b0010;
   localparam logic [3:0] c_alu_sub  = 4'b0110;
   localparam logic [3:0] c_alu_slt  = 4'b0111;
   localparam logic [3:0] c_alu_sltu = 4'b1111;

   // Multiply sequencer states
   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_NEG_A = 3'd1,
      S_NEG_B = 3'd2,
      S_CHECK = 3'd3,
      S_ADD   = 3'd4,
      S_NEG_R = 3'd5,
      S_DONE  = 3'd6
   } seq_state_t;

endpackage : alu_ctrl_pkg
`default_nettype wire

// File: rtl/alu_mul_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module   : alu_mul_sequencer_if
// Brief    : Operand/control bus between an ALU initiator (master) and the
//            combinational ALU (slave).
// Revision : 1.0 - initial release
// ============================================================================
interface alu_mul_sequencer_if #(
   parameter int WIDTH  = 32,
   parameter int CTRL_W = 4
);
   logic [WIDTH-1:0]  alu_src1_o;
   logic [WIDTH-1:0]  alu_src2_o;
   logic [CTRL_W-1:0] alu_ctrl_o;
   logic [WIDTH-1:0]  alu_result_i;
   logic              alu_zero_i;

   // Initiator side: drives operands and op, consumes result and zero flag
   modport master (
      output alu_src1_o,
      output alu_src2_o,
      output alu_ctrl_o,
      input  alu_result_i,
      input  alu_zero_i
   );

   // ALU side
   modport slave (
      input  alu_src1_o,
      input  alu_src2_o,
      input  alu_ctrl_o,
      output alu_result_i,
      output alu_zero_i
   );
endinterface : alu_mul_sequencer_if
`default_nettype wire

// File: rtl/alu_mul_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : alu_mul_sequencer
// Brief    : Multi-cycle shift-add multiplier that borrows the datapath ALU.
//            Produces the low WIDTH bits of a*b, optionally signed (operands
//            and result negated through ALU SUB).
// Revision : 1.0 - initial release
// ============================================================================
module alu_mul_sequencer
   import alu_ctrl_pkg::*;
#(
   parameter int WIDTH  = 32,
   parameter int CTRL_W = 4
) (
   input  logic                clk_i,
   input  logic                rst_i,
   input  logic                start_i,
   input  logic                signed_i,
   input  logic [WIDTH-1:0]    a_i,
   input  logic [WIDTH-1:0]    b_i,
   output logic                busy_o,
   output logic                done_o,
   output logic [WIDTH-1:0]    product_o,
   output logic                prod_zero_o,
   alu_mul_sequencer_if.master alu_bus
);

   seq_state_t        r_state;
   logic [WIDTH-1:0]  r_mcand;
   logic [WIDTH-1:0]  r_mplr;
   logic [WIDTH-1:0]  r_acc;
   logic              r_neg;
   logic              r_sgn;
   logic              r_busy;
   logic              r_done;
   logic [WIDTH-1:0]  r_product;
   logic              r_prod_zero;
   logic [WIDTH-1:0]  r_src1;
   logic [WIDTH-1:0]  r_src2;
   logic [CTRL_W-1:0] r_ctrl;

   seq_state_t        w_state_nxt;
   logic [WIDTH-1:0]  w_mcand_nxt;
   logic [WIDTH-1:0]  w_mplr_nxt;
   logic [WIDTH-1:0]  w_acc_nxt;
   logic              w_neg_nxt;
   logic              w_sgn_nxt;
   logic [WIDTH-1:0]  w_product_nxt;
   logic              w_prod_zero_nxt;
   logic [WIDTH-1:0]  w_src1_nxt;
   logic [WIDTH-1:0]  w_src2_nxt;
   logic [CTRL_W-1:0] w_ctrl_nxt;
   logic [WIDTH-1:0]  w_final_val;

   // Value committed in NEG_R: the ALU holds 0-acc, so pick it only if the
   // operand signs differed.
   assign w_final_val = r_neg ? alu_bus.alu_result_i : r_acc;

   // Next-state and datapath updates; ALU result is consumed in the cycle it is produced
   always_comb begin
      w_state_nxt     = r_state;
      w_mcand_nxt     = r_mcand;
      w_mplr_nxt      = r_mplr;
      w_acc_nxt       = r_acc;
      w_neg_nxt       = r_neg;
      w_sgn_nxt       = r_sgn;
      w_product_nxt   = r_product;
      w_prod_zero_nxt = r_prod_zero;
      case (r_state)
         S_IDLE: begin
            if (start_i) begin
               w_mcand_nxt = a_i;
               w_mplr_nxt  = b_i;
               w_acc_nxt   = '0;
               w_sgn_nxt   = signed_i;
               w_neg_nxt   = signed_i & (a_i[WIDTH-1] ^ b_i[WIDTH-1]);
               w_state_nxt = signed_i ? S_NEG_A : S_CHECK;
            end
         end
         S_NEG_A: begin
            if (r_mcand[WIDTH-1]) w_mcand_nxt = alu_bus.alu_result_i;
            w_state_nxt = S_NEG_B;
         end
         S_NEG_B: begin
            if (r_mplr[WIDTH-1]) w_mplr_nxt = alu_bus.alu_result_i;
            w_state_nxt = S_CHECK;
         end
         S_CHECK: begin
            if (alu_bus.alu_zero_i) begin
               if (r_sgn) begin
                  w_state_nxt = S_NEG_R;
               end else begin
                  w_product_nxt   = r_acc;
                  w_prod_zero_nxt = (r_acc == '0);
                  w_state_nxt     = S_DONE;
               end
            end else if (r_mplr[0]) begin
               w_state_nxt = S_ADD;
            end else begin
               w_mcand_nxt = r_mcand << 1;
               w_mplr_nxt  = r_mplr >> 1;
            end
         end
         S_ADD: begin
            w_acc_nxt   = alu_bus.alu_result_i;
            w_mcand_nxt = r_mcand << 1;
            w_mplr_nxt  = r_mplr >> 1;
            w_state_nxt = S_CHECK;
         end
         S_NEG_R: begin
            w_product_nxt   = w_final_val;
            w_prod_zero_nxt = (w_final_val == '0);
            w_state_nxt     = S_DONE;
         end
         S_DONE: begin
            // A start arriving here is deliberately dropped
            w_state_nxt = S_IDLE;
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   // ALU drive for the state being entered, so the registered bus is valid
   // throughout that state
   always_comb begin
      w_src1_nxt = '0;
      w_src2_nxt = '0;
      w_ctrl_nxt = CTRL_W'(c_alu_and);
      case (w_state_nxt)
         S_NEG_A: begin
            w_ctrl_nxt = CTRL_W'(c_alu_sub);
            w_src2_nxt = w_mcand_nxt;
         end
         S_NEG_B: begin
            w_ctrl_nxt = CTRL_W'(c_alu_sub);
            w_src2_nxt = w_mplr_nxt;
         end
         S_CHECK: begin
            w_ctrl_nxt = CTRL_W'(c_alu_or);
            w_src1_nxt = w_mplr_nxt;
         end
         S_ADD: begin
            w_ctrl_nxt = CTRL_W'(c_alu_add);
            w_src1_nxt = w_acc_nxt;
            w_src2_nxt = w_mcand_nxt;
         end
         S_NEG_R: begin
            w_ctrl_nxt = CTRL_W'(c_alu_sub);
            w_src2_nxt = w_acc_nxt;
         end
         default: begin
            w_ctrl_nxt = CTRL_W'(c_alu_and);
         end
      endcase
   end

   // Sequencer state, datapath and registered outputs; reset aborts any operation
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_state     <= S_IDLE;
         r_mcand     <= '0;
         r_mplr      <= '0;
         r_acc       <= '0;
         r_neg       <= 1'b0;
         r_sgn       <= 1'b0;
         r_busy      <= 1'b0;
         r_done      <= 1'b0;
         r_product   <= '0;
         r_prod_zero <= 1'b1;
         r_src1      <= '0;
         r_src2      <= '0;
         r_ctrl      <= CTRL_W'(c_alu_and);
      end else begin
         r_state     <= w_state_nxt;
         r_mcand     <= w_mcand_nxt;
         r_mplr      <= w_mplr_nxt;
         r_acc       <= w_acc_nxt;
         r_neg       <= w_neg_nxt;
         r_sgn       <= w_sgn_nxt;
         r_busy      <= (w_state_nxt != S_IDLE);
         r_done      <= (w_state_nxt == S_DONE);
         r_product   <= w_product_nxt;
         r_prod_zero <= w_prod_zero_nxt;
         r_src1      <= w_src1_nxt;
         r_src2      <= w_src2_nxt;
         r_ctrl      <= w_ctrl_nxt;
      end
   end

   assign busy_o             = r_busy;
   assign done_o             = r_done;
   assign product_o          = r_product;
   assign prod_zero_o        = r_prod_zero;
   assign alu_bus.alu_src1_o = r_src1;
   assign alu_bus.alu_src2_o = r_src2;
   assign alu_bus.alu_ctrl_o = r_ctrl;

endmodule : alu_mul_sequencer
`default_nettype wire

// File: tb/tb_alu_mul_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_mul_sequencer
// Brief    : Scoreboard bench for alu_mul_sequencer with a behavioural ALU
//            beside it; directed cases followed by random operands.
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_mul_sequencer;

   typedef struct {
      logic [31:0] prod;
      logic        pz;
      int          lat;
      int          t0;
   } exp_t;

   logic        clk_i;
   logic        rst_i;
   logic        start_i;
   logic        signed_i;
   logic [31:0] a_i;
   logic [31:0] b_i;
   logic        busy_o;
   logic        done_o;
   logic [31:0] product_o;
   logic        prod_zero_o;
   logic [31:0] alu_res;

   int   edges = 0;
   int   n_checks = 0;
   int   n_errors = 0;
   int   done_cyc;
   exp_t q[$];
   exp_t mon_e;
   logic       busy_hist[0:127];
   logic [3:0] ctrl_hist[0:127];

   alu_mul_sequencer_if #(.WIDTH(32), .CTRL_W(4)) alu_bus ();

   alu_mul_sequencer #(.WIDTH(32), .CTRL_W(4)) dut (
      .clk_i       (clk_i),
      .rst_i       (rst_i),
      .start_i     (start_i),
      .signed_i    (signed_i),
      .a_i         (a_i),
      .b_i         (b_i),
      .busy_o      (busy_o),
      .done_o      (done_o),
      .product_o   (product_o),
      .prod_zero_o (prod_zero_o),
      .alu_bus     (alu_bus)
   );

   // Behavioural ALU
   always_comb begin
      alu_res = 32'h0;
      case (alu_bus.alu_ctrl_o)
         4'b0000: alu_res = alu_bus.alu_src1_o & alu_bus.alu_src2_o;
         4'b0001: alu_res = alu_bus.alu_src1_o | alu_bus.alu_src2_o;
         4'b0010: alu_res = alu_bus.alu_src1_o + alu_bus.alu_src2_o;
         4'b0110: alu_res = alu_bus.alu_src1_o - alu_bus.alu_src2_o;
         4'b0111: alu_res = {31'h0, $signed(alu_bus.alu_src1_o) < $signed(alu_bus.alu_src2_o)};
         4'b1111: alu_res = {31'h0, alu_bus.alu_src1_o < alu_bus.alu_src2_o};
         default: alu_res = 32'h0;
      endcase
   end
   assign alu_bus.alu_result_i = alu_res;
   assign alu_bus.alu_zero_i   = (alu_res == 32'h0);

   initial clk_i = 1'b0;
   always #5 clk_i = ~clk_i;

   always @(posedge clk_i) edges <= edges + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   // Cycles to done: 2 + bit-length(|b|) + popcount(|b|) + 3 for signed
   function automatic int ref_latency(input logic [31:0] b, input bit sgn);
      logic [31:0] mag;
      int          m;
      mag = (sgn && b[31]) ? 32'(0 - b) : b;
      m = 0;
      for (int i = 0; i < 32; i++) if (mag[i]) m = i + 1;
      return 2 + m + $countones(mag) + (sgn ? 3 : 0);
   endfunction

   // Issue one multiply, push its expected result, wait (bounded) for done
   task automatic run_op(input logic [31:0] a, input logic [31:0] b, input bit sgn,
                         input int extra_start);
      exp_t e;
      bit   seen;
      @(negedge clk_i);
      a_i = a; b_i = b; signed_i = sgn; start_i = 1'b1;
      e.prod = a * b;
      e.pz   = (e.prod == 32'h0);
      e.lat  = ref_latency(b, sgn);
      e.t0   = edges;
      q.push_back(e);
      seen = 1'b0;
      done_cyc = -1;
      for (int n = 1; n <= 200 && !seen; n++) begin
         @(negedge clk_i);
         start_i = (n == extra_start);
         if (n < 128) begin
            busy_hist[n] = busy_o;
            ctrl_hist[n] = alu_bus.alu_ctrl_o;
         end
         if (done_o) begin
            seen = 1'b1;
            done_cyc = n;
         end
      end
      start_i = 1'b0;
      if (!seen) begin
         n_checks++;
         n_errors++;
         $display("FAIL done_timeout: no done_o within 200 cycles (a=%h b=%h)", a, b);
         void'(q.pop_front());
      end
   endtask

   // Monitor: every done_o pulse is compared against the oldest expectation
   initial begin
      forever begin
         @(negedge clk_i);
         if (!rst_i && done_o) begin
            if (q.size() == 0) begin
               n_checks++;
               n_errors++;
               $display("FAIL unexpected_done: done_o at edge %0d, none expected", edges);
            end else begin
               mon_e = q.pop_front();
               check("product", product_o, mon_e.prod);
               check("prod_zero", {31'h0, prod_zero_o}, {31'h0, mon_e.pz});
               check("latency", 32'(edges - mon_e.t0), 32'(mon_e.lat));
            end
         end
      end
   end

   initial begin
      #800000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] ra, rb;
      bit          rs;
      rst_i = 1'b1; start_i = 1'b0; signed_i = 1'b0; a_i = 32'h0; b_i = 32'h0;
      repeat (3) @(negedge clk_i);
      check("rst_busy", {31'h0, busy_o}, 32'h0);
      check("rst_done", {31'h0, done_o}, 32'h0);
      check("rst_product", product_o, 32'h0);
      check("rst_pz", {31'h0, prod_zero_o}, 32'h1);
      check("rst_ctrl", {28'h0, alu_bus.alu_ctrl_o}, 32'h0);
      rst_i = 1'b0;

      // 7 * 6 unsigned
      run_op(32'd7, 32'd6, 1'b0, 0);
      check("u7x6_done_cycle", 32'(done_cyc), 32'd7);
      for (int n = 1; n <= 7; n++) check("u7x6_busy", {31'h0, busy_hist[n]}, 32'h1);
      @(negedge clk_i);
      check("u7x6_busy_idle", {31'h0, busy_o}, 32'h0);
      repeat (3) @(negedge clk_i);
      check("u7x6_held", product_o, 32'd42);

      // -3 * 5 signed
      run_op(32'hFFFF_FFFD, 32'd5, 1'b1, 0);
      check("s_done_cycle", 32'(done_cyc), 32'd10);
      check("s_ctrl_c1", {28'h0, ctrl_hist[1]}, 32'h6);
      check("s_ctrl_c2", {28'h0, ctrl_hist[2]}, 32'h6);
      check("s_ctrl_c9", {28'h0, ctrl_hist[9]}, 32'h6);
      check("s_ctrl_c3", {28'h0, ctrl_hist[3]}, 32'h1);

      // Zero multiplier and wrap-to-zero
      run_op(32'h1234, 32'h0, 1'b0, 0);
      check("b0_done_cycle", 32'(done_cyc), 32'd2);
      run_op(32'h10000, 32'h10000, 1'b0, 0);

      // Long run with an ignored mid-operation start
      run_op(32'd5, 32'h8000_0000, 1'b0, 10);
      check("long_done_cycle", 32'(done_cyc), 32'd35);

      // Asynchronous reset in cycle 4 of a 7x6 run (no expectation queued)
      @(negedge clk_i);
      a_i = 32'd7; b_i = 32'd6; signed_i = 1'b0; start_i = 1'b1;
      @(negedge clk_i);
      start_i = 1'b0;
      repeat (3) @(negedge clk_i);
      #2 rst_i = 1'b1;
      #1;
      check("arst_busy", {31'h0, busy_o}, 32'h0);
      check("arst_done", {31'h0, done_o}, 32'h0);
      check("arst_product", product_o, 32'h0);
      check("arst_pz", {31'h0, prod_zero_o}, 32'h1);
      check("arst_ctrl", {28'h0, alu_bus.alu_ctrl_o}, 32'h0);
      check("arst_src1", alu_bus.alu_src1_o, 32'h0);
      check("arst_src2", alu_bus.alu_src2_o, 32'h0);
      repeat (2) @(negedge clk_i);
      rst_i = 1'b0;
      repeat (12) @(negedge clk_i);
      run_op(32'd3, 32'd3, 1'b0, 0);
      check("post_rst_done_cycle", 32'(done_cyc), 32'd6);

      // Random operands, both modes
      for (int i = 0; i < 40; i++) begin
         ra = $urandom;
         case ($urandom_range(0, 3))
            0: rb = $urandom;
            1: rb = $urandom & 32'hFF;
            2: rb = $urandom_range(0, 3);
            default: rb = 32'h8000_0000 | ($urandom & 32'h0000_0F0F);
         endcase
         if ($urandom_range(0, 4) == 0) ra = 32'h8000_0000;
         rs = bit'($urandom_range(0, 1));
         run_op(ra, rb, rs, 0);
      end

      repeat (5) @(negedge clk_i);
      check("queue_drained", 32'(q.size()), 32'h0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule : tb_alu_mul_sequencer
`default_nettype wire
